// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
//
// Handshake: ReqIn[n] is a level held by requester n for as long as it wants
// the resource. Requester n owns the select lines exactly while
// GrantValid=1 and GrantIdx=n, which is the same as GrantOut[n]=1. A
// requester gives up ownership by lowering ReqIn[n]; the grant drops on the
// following cycle. Timeout pulses on the first dead cycle after a grant was
// cut off at the hold limit.
interface rr_arbiter8_if;
  logic [7:0] ReqIn;
  logic [7:0] GrantOut;
  logic [2:0] GrantIdx;
  logic       GrantValid;
  logic       Timeout;

  // Arbiter side.
  modport master (
    input  ReqIn,
    output GrantOut,
    output GrantIdx,
    output GrantValid,
    output Timeout
  );

  // Requester side.
  modport slave (
    output ReqIn,
    input  GrantOut,
    input  GrantIdx,
    input  GrantValid,
    input  Timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with a registered one-hot grant, a hold limit
// and one forced dead cycle between grants (break-before-make on selects).
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_arbiter8_if.master       bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       grant_idx, grant_idx_n;
  logic             grant_valid, grant_valid_n;
  logic             timeout, timeout_n;

  logic             found;
  logic [2:0]       winner;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Pick the first requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] cand;
      cand = ptr + 3'(i);
      if (!found && bus.ReqIn[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and next-output decision for the grant FSM.
  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    cnt_n         = cnt;
    grant_idx_n   = grant_idx;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;

    unique case (state)
      IDLE, GAP: begin
        // The GAP cycle arbitrates too, already using the advanced ptr.
        if (found) begin
          state_n       = GRANT;
          grant_idx_n   = winner;
          grant_valid_n = 1'b1;
          cnt_n         = '0;
        end else begin
          state_n       = IDLE;
          grant_idx_n   = 3'd0;
          grant_valid_n = 1'b0;
          cnt_n         = '0;
        end
      end
      GRANT: begin
        cnt_n = cnt + 1'b1;
        // Release is checked first so it wins over a simultaneous timeout.
        if (!bus.ReqIn[grant_idx]) begin
          state_n       = GAP;
          grant_idx_n   = 3'd0;
          grant_valid_n = 1'b0;
          ptr_n         = grant_idx + 3'd1;
        end else if (cnt == HOLD_LAST) begin
          state_n       = GAP;
          grant_idx_n   = 3'd0;
          grant_valid_n = 1'b0;
          timeout_n     = 1'b1;
          ptr_n         = grant_idx + 3'd1;
        end
      end
      default: begin
        state_n       = IDLE;
        grant_idx_n   = 3'd0;
        grant_valid_n = 1'b0;
        cnt_n         = '0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= '0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      grant_idx   <= grant_idx_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
    end
  end

  // Outputs come straight from registers; ReqIn never reaches them combinationally.
  assign bus.GrantOut   = grant_valid ? (8'b1 << grant_idx) : 8'h00;
  assign bus.GrantIdx   = grant_idx;
  assign bus.GrantValid = grant_valid;
  assign bus.Timeout    = timeout;
  assign state_dbg      = state;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one 8-way one-hot select resource among up to 8 masters.
- Produces a registered one-hot grant (bit n = requester n) plus a binary grant index.
- Grant is held while the winner keeps requesting, bounded by a hold limit.
- Sits in front of the 3-to-8 select decode path and replaces ad-hoc select driving with a fair, sequenced grant.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one requester may hold the grant; legal range 2..255.
- CNT_W, 8: width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- ReqIn  input  8  request vector; bit n high = requester n wants the resource; level-held by requester.
- GrantOut  output  8  one-hot grant, registered; all-zero when no grant.
- GrantIdx  output  3  binary index of current grantee; 0 when no grant.
- GrantValid  output  1  high while GrantOut is non-zero.
- Timeout  output  1  one-cycle pulse when a grant is forcibly ended at MAX_HOLD.

Behaviour:
- Reset (rst high at a clk edge): next cycle GrantOut=8'h00, GrantIdx=0, GrantValid=0, Timeout=0, state=IDLE, ptr=0, hold count=0. Applies in any state, including mid-grant; the grant drops with no GAP cycle.
- ptr (3 bits) is the highest-priority index. Priority order is ptr, ptr+1, ..., ptr+7, mod 8 (wraps 7->0).
- States: IDLE, GRANT, GAP.
- IDLE:
  - If ReqIn != 0, the winner is the first set bit in priority order; next cycle state=GRANT, GrantOut=1<<winner, GrantIdx=winner, GrantValid=1, count=0.
  - Else remain IDLE with outputs zero.
  - Latency from request to grant: 1 cycle.
- GRANT:
  - Each cycle count increments; ReqIn bits other than GrantIdx are ignored.
  - If ReqIn[GrantIdx]=0: next cycle state=GAP, grant outputs zero, ptr=GrantIdx+1 (mod 8).
  - Else if count==MAX_HOLD-1: next cycle state=GAP, grant outputs zero, Timeout=1 for exactly that cycle, ptr=GrantIdx+1.
  - Release takes precedence over timeout when both occur in the same cycle; Timeout stays 0.
  - A grant lasts at most MAX_HOLD cycles with GrantValid=1.
- GAP:
  - Exactly one dead cycle with all grant outputs zero; guarantees break-before-make on the select lines.
  - During GAP, arbitration runs as in IDLE using the updated ptr. If any request, next cycle is GRANT to the new winner; otherwise next cycle is IDLE.
  - The previous grantee, if still requesting, gets lowest priority; it wins again only if it is the sole requester.
- Invariants (verification assertions):
  - GrantOut is always one-hot or zero.
  - GrantOut == (GrantValid ? 1<<GrantIdx : 0).
  - Timeout is never high in two consecutive cycles.
- ReqIn is sampled only at clk edges; no combinational path from ReqIn to any output.
- Starvation bound: a requester holding ReqIn high is granted within 7*(MAX_HOLD+1)+1 cycles.

Test Plan:
- Reset: assert rst for 2 cycles with ReqIn=8'hFF -> all outputs 0 during and 1 cycle after; first grant after reset release is GrantOut=8'h01.
- Single request: ReqIn=8'h20 for 3 cycles then 0 -> GrantOut=8'h20, GrantIdx=5, GrantValid=1 from the cycle after the request; GAP after release, then IDLE, outputs 0.
- Rotation: ReqIn=8'h81 held, each requester drops its bit 2 cycles after being granted and re-raises it immediately -> grants alternate 8'h01, 8'h80, 8'h01, ..., with exactly 1 zero cycle between grants.
- Timeout (MAX_HOLD=4): ReqIn=8'h04 held constantly -> GrantOut=8'h04 for 4 cycles, Timeout=1 on the following GAP cycle, then 8'h04 re-granted for 4 cycles (sole requester).
- Wrap and fairness: ptr at 6 after releasing index 5, ReqIn=8'h43 -> grant order 6, 0, 1, then 6.
- Reset mid-grant: rst asserted while GrantOut=8'h08 -> next cycle GrantOut=0, Timeout=0; after rst release with ReqIn=8'h0C, grant goes to index 2 (ptr=0).
